// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32IM pipeline front end.
//   NOP_INSTR_DEFAULT  : bubble encoding (ADDI x0, x0, 0)
//   RESET_PC_DEFAULT   : default program counter after reset
//   fetch_state_e      : fetch FSM states (RUN fetching, HALT out of range)
//   ifid_t             : contents of the IF/ID pipeline register
//   ifid_bubble()      : builds a squashed IF/ID entry
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    // A bubble carries the NOP encoding, zeroed PCs and no valid flag so the
    // decode stage treats it as a harmless no-op.
    function automatic ifid_t ifid_bubble(input logic [31:0] nop);
        ifid_t b;
        b.instruction = nop;
        b.pc          = 32'h0;
        b.pc_plus4    = 32'h0;
        b.valid       = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ifid_pipeline_register.sv
// ---------------------------------------------------------------------------
// ifid_pipeline_register
// Generic pipeline register holding instruction / PC / PC+4 / valid.
// Ports:
//   clk    in   clock, rising edge
//   srst   in   synchronous active-high reset, loads a bubble
//   hold   in   keep current contents (stall)
//   flush  in   load a bubble; wins over hold
//   d      in   entry to capture on a normal advance
//   q      out  registered entry
// ---------------------------------------------------------------------------
module ifid_pipeline_register
    import rv32_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  srst,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d = ifid_bubble(NOP_INSTR);
        end else if (!hold) begin
            ifid_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ifid_q <= ifid_bubble(NOP_INSTR);
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q = ifid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
// IF stage of the RV32IM 5-stage pipeline. Owns the PC, drives the
// combinational instruction memory, fills the IF/ID register, handles
// stalls, EX redirects and halts when the PC leaves instruction memory.
// Ports:
//   CLK               in   clock
//   RESET             in   synchronous active-high reset
//   STALL             in   hold PC and IF/ID
//   BRANCH_TAKEN      in   redirect fetch (beats STALL)
//   BRANCH_TARGET     in   redirect byte address
//   IMEM_ADDRESS      out  PC, straight to instruction memory
//   IMEM_INSTRUCTION  in   word at IMEM_ADDRESS, same cycle
//   IFID_INSTRUCTION  out  registered instruction
//   IFID_PC           out  registered PC of that instruction
//   IFID_PC_PLUS4     out  registered PC + 4
//   IFID_VALID        out  1 = real instruction, 0 = bubble
//   FETCH_MISALIGNED  out  one-cycle pulse, redirect target not word aligned
//   FETCH_HALTED      out  high while halted
// ---------------------------------------------------------------------------
module instruction_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_SIZE = 1024,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_INSTRUCTION,
    output logic [31:0] IFID_INSTRUCTION,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC_PLUS4,
    output logic        IFID_VALID,
    output logic        FETCH_MISALIGNED,
    output logic        FETCH_HALTED
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_SIZE);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misaligned_q, misaligned_d;

    logic         ifid_hold;
    logic         ifid_flush;
    ifid_t        ifid_in;
    ifid_t        ifid_out;

    // Entry captured on a normal fetch; only loaded when neither hold nor
    // flush is asserted.
    always_comb begin
        ifid_in.instruction = IMEM_INSTRUCTION;
        ifid_in.pc          = pc_q;
        ifid_in.pc_plus4    = pc_q + 32'd4;
        ifid_in.valid       = 1'b1;
    end

    // Next-PC mux and halt FSM. Redirect beats stall so a taken branch is
    // never lost behind a hazard stall; the misaligned flag is a pulse and
    // therefore defaults to 0 on every non-redirect edge.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;

        if (BRANCH_TAKEN) begin
            pc_d         = {BRANCH_TARGET[31:2], 2'b00};
            state_d      = RUN;
            ifid_flush   = 1'b1;
            misaligned_d = |BRANCH_TARGET[1:0];
        end else if (STALL) begin
            ifid_hold = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (pc_q < IMEM_LIMIT) begin
                        pc_d = pc_q + 32'd4;
                    end else begin
                        // PC walked off the end of memory: park here and
                        // keep the pipeline fed with bubbles.
                        state_d    = HALT;
                        ifid_flush = 1'b1;
                    end
                end
                HALT: begin
                    ifid_flush = 1'b1;
                end
                default: begin
                    state_d    = RUN;
                    ifid_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    ifid_pipeline_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk   (CLK),
        .srst  (RESET),
        .hold  (ifid_hold),
        .flush (ifid_flush),
        .d     (ifid_in),
        .q     (ifid_out)
    );

    assign IMEM_ADDRESS     = pc_q;
    assign IFID_INSTRUCTION = ifid_out.instruction;
    assign IFID_PC          = ifid_out.pc;
    assign IFID_PC_PLUS4    = ifid_out.pc_plus4;
    assign IFID_VALID       = ifid_out.valid;
    assign FETCH_MISALIGNED = misaligned_q;
    assign FETCH_HALTED     = (state_q == HALT);

endmodule
